pipe_stage_reg: RTL and testbench

- Parametrised, elastic pipeline stage register for the 32-bit MIPS datapath. It is the generic successor to the fixed ID/EX stage register.
- Carries a control bundle and a data bundle with a valid/ready handshake, a 2-entry skid buffer for back-pressure, and synchronous flush.
- Instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so hazard stalls propagate as back-pressure instead of ad-hoc enables.

---
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 tb/tb_pipe_stage_reg.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: control + data bundles, valid/ready handshake,
// 2-entry skid buffer and synchronous flush. Optional stall counter: PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 160,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]       Stall_Count
`endif
);

    logic              m_valid, m_valid_nxt;
    logic [CTRL_W-1:0] m_ctrl,  m_ctrl_nxt;
    logic [DATA_W-1:0] m_data,  m_data_nxt;
    logic              s_valid, s_valid_nxt;
    logic [CTRL_W-1:0] s_ctrl,  s_ctrl_nxt;
    logic [DATA_W-1:0] s_data,  s_data_nxt;
    logic              in_ready_q;
    logic              accept;

    assign accept    = In_Valid & in_ready_q;
    assign In_Ready  = in_ready_q;
    assign Out_Valid = m_valid;
    assign Out_Ctrl  = m_ctrl;
    assign Out_Data  = m_data;

    // M refills from S first so entries leave in arrival order; S only fills while M is stuck.
    always_comb begin
        m_valid_nxt = m_valid;
        m_ctrl_nxt  = m_ctrl;
        m_data_nxt  = m_data;
        s_valid_nxt = s_valid;
        s_ctrl_nxt  = s_ctrl;
        s_data_nxt  = s_data;
        if (!m_valid || Out_Ready) begin
            if (s_valid) begin
                m_valid_nxt = 1'b1;
                m_ctrl_nxt  = s_ctrl;
                m_data_nxt  = s_data;
                s_valid_nxt = accept;
                if (accept) begin
                    s_ctrl_nxt = In_Ctrl;
                    s_data_nxt = In_Data;
                end
            end else if (accept) begin
                m_valid_nxt = 1'b1;
                m_ctrl_nxt  = In_Ctrl;
                m_data_nxt  = In_Data;
            end else begin
                m_valid_nxt = 1'b0;
                m_ctrl_nxt  = BUBBLE_CTRL;
            end
        end else if (accept) begin
            s_valid_nxt = 1'b1;
            s_ctrl_nxt  = In_Ctrl;
            s_data_nxt  = In_Data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            m_valid    <= 1'b0;
            m_ctrl     <= BUBBLE_CTRL;
            m_data     <= '0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid    <= m_valid_nxt;
            m_ctrl     <= m_ctrl_nxt;
            m_data     <= m_data_nxt;
            s_valid    <= s_valid_nxt;
            in_ready_q <= !s_valid_nxt;
        end
    end

    // Skid payload is only observed through s_valid, so it needs no reset.
    always_ff @(posedge Clock) begin
        s_ctrl <= s_ctrl_nxt;
        s_data <= s_data_nxt;
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Stall_Count <= '0;
        end else if (m_valid && !Out_Ready && (Stall_Count != 32'hFFFF_FFFF)) begin
            Stall_Count <= Stall_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg; entries are queued when accepted and
// compared when the stage presents them. Stall counter checked when PIPE_STAGE_PERF_CNT_EN is set.
module tb_pipe_stage_reg;

    localparam int                CTRL_W = 16;
    localparam int                DATA_W = 160;
    localparam logic [CTRL_W-1:0] BUBBLE = 16'hB000;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              Clock = 1'b0;
    logic              Reset, Flush, In_Valid, Out_Ready;
    logic              In_Ready, Out_Valid;
    logic [CTRL_W-1:0] In_Ctrl, Out_Ctrl;
    logic [DATA_W-1:0] In_Data, Out_Data;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]       Stall_Count;
`endif

    int                assertions = 0;
    int                failures   = 0;
    entry_t            sb[$];
    logic              model_ready;
    logic [DATA_W-1:0] model_last;
    logic [31:0]       model_stall;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BUBBLE)) dut (
        .Clock(Clock), .Reset(Reset), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .Stall_Count(Stall_Count)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model, clock.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                                 input logic ordy);
        logic   drain, accept;
        entry_t e;
        @(negedge Clock);
        Reset = rst; Flush = fl; In_Valid = iv; In_Ctrl = ic; In_Data = id; Out_Ready = ordy;
        #1;
        checkOutput("in_ready", {191'd0, In_Ready}, {191'd0, model_ready});
        checkOutput("out_valid", {191'd0, Out_Valid}, {191'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            checkOutput("out_ctrl", {176'd0, Out_Ctrl}, {176'd0, sb[0].ctrl});
            checkOutput("out_data", {32'd0, Out_Data}, {32'd0, sb[0].data});
        end else begin
            checkOutput("bubble_ctrl", {176'd0, Out_Ctrl}, {176'd0, BUBBLE});
            checkOutput("bubble_data", {32'd0, Out_Data}, {32'd0, model_last});
        end
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("stall_count", {160'd0, Stall_Count}, {160'd0, model_stall});
`endif
        drain  = (sb.size() > 0) && ordy;
        accept = iv && model_ready;
        if (rst) model_stall = 32'd0;
        else if ((sb.size() > 0) && !ordy && model_stall != 32'hFFFF_FFFF) model_stall++;
        if (rst || fl) begin
            sb.delete();
            model_ready = 1'b1;
            model_last  = '0;
        end else begin
            if (drain) begin
                e = sb.pop_front();
                model_last = e.data;
            end
            if (accept) sb.push_back({ic, id});
            model_ready = (sb.size() < 2);
        end
        @(posedge Clock);
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b1; In_Ctrl = 16'h1234; In_Data = 160'h99; Out_Ready = 1'b0;
        @(posedge Clock);
        model_ready = 1'b1; model_last = '0; model_stall = 32'd0;

        $display("[TB] reset then idle");
        applyStimulus(1, 0, 1, 16'h1234, 160'h99, 0);
        applyStimulus(1, 0, 1, 16'h1234, 160'h99, 0);
        applyStimulus(0, 0, 0, 16'h0000, 160'h0, 1);

        $display("[TB] streaming");
        for (int k = 1; k <= 4; k++)
            applyStimulus(0, 0, 1, 16'h0101 * k[15:0], DATA_W'(k), 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);

        $display("[TB] back-pressure");
        applyStimulus(0, 0, 1, 16'h0A0A, 160'd10, 1);
        applyStimulus(0, 0, 1, 16'h0B0B, 160'd11, 1);
        applyStimulus(0, 0, 1, 16'h0C0C, 160'd12, 0);
        applyStimulus(0, 0, 1, 16'h0D0D, 160'd13, 0);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 0);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("stall_after_bp", {160'd0, Stall_Count}, {160'd0, 32'd3});
`endif

        $display("[TB] flush with skid full");
        applyStimulus(0, 0, 1, 16'h1414, 160'd20, 1);
        applyStimulus(0, 0, 1, 16'h1515, 160'd21, 0);
        applyStimulus(0, 1, 1, 16'h1616, 160'd22, 0);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);

        $display("[TB] drain to bubble");
        applyStimulus(0, 0, 1, 16'h00FF, 160'h55, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        checkOutput("bubble_keeps_data", {32'd0, Out_Data}, {32'd0, 160'h55});

        $display("[TB] reset priority over flush");
        applyStimulus(0, 0, 1, 16'h0707, 160'h70, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 0);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 0);
        applyStimulus(0, 1, 0, 16'h0, 160'h0, 1);
`ifdef PIPE_STAGE_PERF_CNT_EN
        checkOutput("stall_survives_flush", {160'd0, Stall_Count}, {160'd0, 32'd7});
`endif
        applyStimulus(1, 1, 1, 16'h0808, 160'h80, 0);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);
        applyStimulus(0, 0, 0, 16'h0, 160'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
